icache_ctrl: RTL and testbench

ICACHE_CTRL -- requirements
Module: icache_ctrl

---
 rtl/icache_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_icache_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: 1-cycle hits, whole-block refill
// from word 0 on a miss, single-beat uncached bypass, and deferred flush.
//
// state  | meaning
// IDLE   | accept requests, serve hits, apply flushes
// REFILL | fetch all BLOCK_WORDS beats of the missing line
// BYPASS | one uncached beat at the request address
// RESP   | miss/bypass response pulse, then back to IDLE
module icache_ctrl #(
    parameter int WORD_SIZE = 32,
    parameter int OFFSET_W  = 4,
    parameter int INDEX_W   = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cache_enable,
    input  logic                 flush,
    input  logic                 req_valid,
    input  logic [WORD_SIZE-1:0] req_addr,
    output logic                 req_ready,
    output logic                 resp_valid,
    output logic [WORD_SIZE-1:0] resp_inst,
    output logic                 hit,
    output logic                 mem_req,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_data
);

    localparam int BLOCK_WORDS = 2 ** OFFSET_W;
    localparam int LINES       = 2 ** INDEX_W;
    localparam int TAG_W       = WORD_SIZE - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {IDLE, REFILL, BYPASS, RESP} state_t;

    state_t state, state_nxt;

    logic [WORD_SIZE-1:0] lat_addr;
    logic [WORD_SIZE-1:0] fill_word;
    logic [OFFSET_W-1:0]  cnt;
    logic                 flush_pending;
    logic [LINES-1:0]     valid;

    // Tag and data arrays are never reset; valid bits alone qualify them.
    logic [TAG_W-1:0]     tag_mem  [LINES];
    logic [WORD_SIZE-1:0] data_mem [LINES][BLOCK_WORDS];

    logic [OFFSET_W-1:0] req_off, lat_off;
    logic [INDEX_W-1:0]  req_idx, lat_idx;
    logic [TAG_W-1:0]    req_tag, lat_tag;
    logic                line_hit;
    logic                accept;
    logic                flush_now;
    logic                last_beat;

    assign req_off = req_addr[OFFSET_W-1:0];
    assign req_idx = req_addr[OFFSET_W +: INDEX_W];
    assign req_tag = req_addr[WORD_SIZE-1 -: TAG_W];
    assign lat_off = lat_addr[OFFSET_W-1:0];
    assign lat_idx = lat_addr[OFFSET_W +: INDEX_W];
    assign lat_tag = lat_addr[WORD_SIZE-1 -: TAG_W];

    assign line_hit  = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign accept    = req_valid && req_ready;
    assign flush_now = (state == IDLE) && (flush || flush_pending);
    assign last_beat = (state == REFILL) && mem_ack && (cnt == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        case (state)
            IDLE: begin
                req_ready = !flush && !flush_pending;
                if (req_valid && req_ready) begin
                    if (!cache_enable) begin
                        state_nxt = BYPASS;
                    end else if (!line_hit) begin
                        state_nxt = REFILL;
                    end
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {lat_tag, lat_idx, cnt};
                if (mem_ack && (cnt == '1)) begin
                    state_nxt = RESP;
                end
            end
            BYPASS: begin
                mem_req  = 1'b1;
                mem_addr = lat_addr;
                if (mem_ack) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr      <= '0;
            fill_word     <= '0;
            cnt           <= '0;
            flush_pending <= 1'b0;
            valid         <= '0;
            resp_valid    <= 1'b0;
            hit           <= 1'b0;
            resp_inst     <= '0;
        end else begin
            resp_valid <= 1'b0;
            hit        <= 1'b0;

            if (flush && (state != IDLE)) begin
                flush_pending <= 1'b1;
            end
            if (flush_now) begin
                valid         <= '0;
                flush_pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_addr <= req_addr;
                        cnt      <= '0;
                        if (cache_enable && line_hit) begin
                            resp_valid <= 1'b1;
                            hit        <= 1'b1;
                            resp_inst  <= data_mem[req_idx][req_off];
                        end
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        cnt <= cnt + OFFSET_W'(1);
                        if (cnt == lat_off) begin
                            fill_word <= mem_data;
                        end
                        // The requested word may arrive on the final beat itself.
                        if (cnt == '1) begin
                            valid[lat_idx] <= 1'b1;
                            resp_valid     <= 1'b1;
                            resp_inst      <= (cnt == lat_off) ? mem_data : fill_word;
                        end
                    end
                end
                BYPASS: begin
                    if (mem_ack) begin
                        resp_valid <= 1'b1;
                        resp_inst  <= mem_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == REFILL) && mem_ack) begin
            data_mem[lat_idx][cnt] <= mem_data;
        end
        if (last_beat) begin
            tag_mem[lat_idx] <= lat_tag;
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: memory returns its own word address as data,
// so every expected instruction equals the requested address.
module tb_icache_ctrl;

    logic        clk;
    logic        rst;
    logic        cache_enable;
    logic        flush;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        hit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;

    int tests    = 0;
    int failed   = 0;
    int timeouts = 0;
    int addr_viol = 0;

    icache_ctrl dut (
        .clk(clk),
        .rst(rst),
        .cache_enable(cache_enable),
        .flush(flush),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .resp_valid(resp_valid),
        .resp_inst(resp_inst),
        .hit(hit),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_data(mem_data)
    );

    assign mem_data = mem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [31:0] addr;
        logic        exp_hit;
        logic [31:0] exp_inst;
        int          exp_lat;
        int          exp_beats;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_req(input logic en, input logic [31:0] addr,
                           output logic [31:0] inst, output logic h, output int lat,
                           output int beats, output logic [31:0] first_a,
                           output logic [31:0] last_a);
        int  n;
        bit  done;
        inst = '0; h = 1'b0; lat = 0; beats = 0; first_a = '0; last_a = '0;
        @(negedge clk);
        cache_enable = en;
        req_valid    = 1'b1;
        req_addr     = addr;
        #1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready) timeouts++;
        @(posedge clk);
        done = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            req_valid    = 1'b0;
            cache_enable = ~en;   // must not affect the transaction in flight
            lat++;
            if (mem_req && mem_ack) begin
                if (beats == 0) first_a = mem_addr;
                last_a = mem_addr;
                beats++;
            end
            if (!mem_req && mem_addr != 32'h0) addr_viol++;
            if (resp_valid) begin
                done = 1;
                inst = resp_inst;
                h    = hit;
            end
        end
        if (!done) timeouts++;
    endtask

    logic [31:0] r_inst, r_first, r_last;
    logic        r_hit;
    int          r_lat, r_beats;

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0013, 1'b0, 32'h0000_0013, 17, 16, 32'h0000_0010, 32'h0000_001F};
        vecs[1]  = '{1'b1, 32'h0000_0015, 1'b1, 32'h0000_0015,  1,  0, 32'h0,         32'h0};
        vecs[2]  = '{1'b1, 32'h0000_0010, 1'b1, 32'h0000_0010,  1,  0, 32'h0,         32'h0};
        vecs[3]  = '{1'b1, 32'h0000_001F, 1'b1, 32'h0000_001F,  1,  0, 32'h0,         32'h0};
        vecs[4]  = '{1'b1, 32'h0000_4013, 1'b0, 32'h0000_4013, 17, 16, 32'h0000_4010, 32'h0000_401F};
        vecs[5]  = '{1'b1, 32'h0000_0013, 1'b0, 32'h0000_0013, 17, 16, 32'h0000_0010, 32'h0000_001F};
        vecs[6]  = '{1'b0, 32'h0000_0020, 1'b0, 32'h0000_0020,  2,  1, 32'h0000_0020, 32'h0000_0020};
        vecs[7]  = '{1'b1, 32'h0000_0020, 1'b0, 32'h0000_0020, 17, 16, 32'h0000_0020, 32'h0000_002F};
        vecs[8]  = '{1'b0, 32'h0000_0013, 1'b0, 32'h0000_0013,  2,  1, 32'h0000_0013, 32'h0000_0013};
        vecs[9]  = '{1'b1, 32'h0000_0013, 1'b1, 32'h0000_0013,  1,  0, 32'h0,         32'h0};
        vecs[10] = '{1'b1, 32'h0000_002F, 1'b1, 32'h0000_002F,  1,  0, 32'h0,         32'h0};
        vecs[11] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 17, 16, 32'hFFFF_FFF0, 32'hFFFF_FFFF};
        vecs[12] = '{1'b1, 32'hFFFF_FFF0, 1'b1, 32'hFFFF_FFF0,  1,  0, 32'h0,         32'h0};

        rst = 1'b1; cache_enable = 1'b1; flush = 1'b0; req_valid = 1'b0;
        req_addr = '0; mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", {31'b0, req_ready}, 32'h1);
        check("reset_mem_req", {31'b0, mem_req}, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("reset_hit", {31'b0, hit}, 32'h0);
        check("reset_resp_inst", resp_inst, 32'h0);

        for (int i = 0; i < 13; i++) begin
            run_req(vecs[i].en, vecs[i].addr, r_inst, r_hit, r_lat, r_beats, r_first, r_last);
            check($sformatf("v%0d_hit", i), {31'b0, r_hit}, {31'b0, vecs[i].exp_hit});
            check($sformatf("v%0d_inst", i), r_inst, vecs[i].exp_inst);
            check($sformatf("v%0d_latency", i), r_lat, vecs[i].exp_lat);
            check($sformatf("v%0d_beats", i), r_beats, vecs[i].exp_beats);
            check($sformatf("v%0d_first_addr", i), r_first, vecs[i].exp_first);
            check($sformatf("v%0d_last_addr", i), r_last, vecs[i].exp_last);
        end

        // Back-to-back hits on line 1 at one request per cycle.
        @(negedge clk);
        cache_enable = 1'b1; req_valid = 1'b1; req_addr = 32'h11;
        @(negedge clk);
        check("b2b_0_valid", {31'b0, resp_valid & hit}, 32'h1);
        check("b2b_0_inst", resp_inst, 32'h11);
        req_addr = 32'h12;
        @(negedge clk);
        check("b2b_1_valid", {31'b0, resp_valid & hit}, 32'h1);
        check("b2b_1_inst", resp_inst, 32'h12);
        check("b2b_mem_req", {31'b0, mem_req}, 32'h0);
        req_addr = 32'h1A;
        @(negedge clk);
        check("b2b_2_valid", {31'b0, resp_valid & hit}, 32'h1);
        check("b2b_2_inst", resp_inst, 32'h1A);
        req_valid = 1'b0;

        // Flush pulsed mid-refill of line 3 while line 1 is valid.
        begin
            int  cyc;
            bit  got;
            @(negedge clk);
            cache_enable = 1'b1; req_valid = 1'b1; req_addr = 32'h30;
            @(posedge clk);
            cyc = 0; got = 0;
            while (!got && cyc < 60) begin
                @(negedge clk);
                req_valid = 1'b0;
                cyc++;
                flush = (cyc == 6);
                if (resp_valid) got = 1;
            end
            flush = 1'b0;
            if (!got) timeouts++;
            check("flush_mid_latency", cyc, 17);
            @(negedge clk);
            check("flush_pending_ready", {31'b0, req_ready}, 32'h0);
            @(negedge clk);
            check("after_flush_ready", {31'b0, req_ready}, 32'h1);
        end
        run_req(1'b1, 32'h13, r_inst, r_hit, r_lat, r_beats, r_first, r_last);
        check("flush_line1_hit", {31'b0, r_hit}, 32'h0);
        check("flush_line1_beats", r_beats, 16);
        run_req(1'b1, 32'h30, r_inst, r_hit, r_lat, r_beats, r_first, r_last);
        check("flush_line3_hit", {31'b0, r_hit}, 32'h0);
        check("flush_line3_inst", r_inst, 32'h30);

        // Flush in IDLE blocks acceptance that cycle and invalidates line 3.
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h30;
        #1;
        check("idle_flush_ready", {31'b0, req_ready}, 32'h0);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        check("idle_flush_no_resp", {31'b0, resp_valid}, 32'h0);
        run_req(1'b1, 32'h30, r_inst, r_hit, r_lat, r_beats, r_first, r_last);
        check("idle_flush_miss", {31'b0, r_hit}, 32'h0);
        check("idle_flush_latency", r_lat, 17);

        // Reset after 5 beats of a refill.
        begin
            int beats;
            int n;
            @(negedge clk);
            cache_enable = 1'b1; req_valid = 1'b1; req_addr = 32'h50;
            @(posedge clk);
            beats = 0; n = 0;
            while (beats < 5 && n < 40) begin
                @(negedge clk);
                req_valid = 1'b0;
                n++;
                if (mem_req && mem_ack) beats++;
            end
            if (beats < 5) timeouts++;
            rst = 1'b1;
            #1;
            check("rst_mid_mem_req", {31'b0, mem_req}, 32'h0);
            check("rst_mid_mem_addr", mem_addr, 32'h0);
            check("rst_mid_resp_valid", {31'b0, resp_valid}, 32'h0);
            @(negedge clk);
            rst = 1'b0;
        end
        run_req(1'b1, 32'h50, r_inst, r_hit, r_lat, r_beats, r_first, r_last);
        check("rerefill_hit", {31'b0, r_hit}, 32'h0);
        check("rerefill_beats", r_beats, 16);
        check("rerefill_first", r_first, 32'h50);
        check("rerefill_latency", r_lat, 17);
        check("rerefill_inst", r_inst, 32'h50);
        run_req(1'b1, 32'h5C, r_inst, r_hit, r_lat, r_beats, r_first, r_last);
        check("post_rerefill_hit", {31'b0, r_hit}, 32'h1);
        check("post_rerefill_inst", r_inst, 32'h5C);

        check("timeouts", timeouts, 0);
        check("mem_addr_zero_when_idle", addr_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
